// File: rtl/boot_loader_wr.sv
// Boot-time memory writer: unpacks a framed UART byte stream into 32-bit RAM writes
// and releases core fetch only after the whole image passes its XOR checksum.
module boot_loader_wr #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fetch_en_o,
    output logic                  err_o
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_dw
            $error("boot_loader_wr: DATA_WIDTH must be 32");
        end
        if (ADDR_WIDTH < 3) begin : g_bad_aw
            $error("boot_loader_wr: ADDR_WIDTH must be at least 3");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR_A, ST_HDR_C, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERR
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_ld;
    logic [31:0]           r_sh, w_sh_nxt, r_wdata;
    logic [15:0]           r_cnt;
    logic [1:0]            r_idx;
    logic [7:0]            r_xor;
    logic                  r_req;
    logic [3:0]            r_be;
    logic                  w_acc;

    assign w_acc    = rx_valid_i && rx_ready_o;
    // Bytes arrive LSB first, so shift in from the top.
    assign w_sh_nxt = {rx_data_i, r_sh[31:8]};

    generate
        if (ADDR_WIDTH <= 32) begin : g_addr_narrow
            assign w_addr_ld = w_sh_nxt[ADDR_WIDTH-1:0];
        end else begin : g_addr_wide
            assign w_addr_ld = {{(ADDR_WIDTH-32){1'b0}}, w_sh_nxt};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_acc && rx_data_i == 8'hA5) w_state_nxt = ST_HDR_A;
            ST_HDR_A: if (w_acc && r_idx == 2'd3)
                          w_state_nxt = (w_sh_nxt[1:0] != 2'b00) ? ST_ERR : ST_HDR_C;
            ST_HDR_C: if (w_acc && r_idx == 2'd1)
                          w_state_nxt = ({rx_data_i, r_cnt[7:0]} == 16'd0) ? ST_CHK : ST_DATA;
            ST_DATA:  if (w_acc && r_idx == 2'd3) w_state_nxt = ST_WRITE;
            ST_WRITE: if (mem_gnt_i) w_state_nxt = (r_cnt == 16'd1) ? ST_CHK : ST_DATA;
            ST_CHK:   if (w_acc) w_state_nxt = (rx_data_i == r_xor) ? ST_DONE : ST_ERR;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_sh    <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_xor   <= '0;
            r_req   <= 1'b0;
            r_be    <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            // Request is a registered copy of "next state is WRITE".
            r_req   <= (w_state_nxt == ST_WRITE);
            r_be    <= (w_state_nxt == ST_WRITE) ? 4'hF : 4'h0;
            if (w_acc) begin
                case (r_state)
                    ST_IDLE: begin
                        r_xor <= 8'h00;
                        r_idx <= 2'd0;
                    end
                    ST_HDR_A: begin
                        r_sh  <= w_sh_nxt;
                        r_xor <= r_xor ^ rx_data_i;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_addr <= w_addr_ld;
                    end
                    ST_HDR_C: begin
                        r_xor <= r_xor ^ rx_data_i;
                        r_idx <= (r_idx == 2'd1) ? 2'd0 : r_idx + 2'd1;
                        if (r_idx == 2'd0) r_cnt[7:0]  <= rx_data_i;
                        else               r_cnt[15:8] <= rx_data_i;
                    end
                    ST_DATA: begin
                        r_sh  <= w_sh_nxt;
                        r_xor <= r_xor ^ rx_data_i;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_wdata <= w_sh_nxt;
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_WRITE && mem_gnt_i) begin
                r_addr <= r_addr + ADDR_WIDTH'(4);
                r_cnt  <= r_cnt - 16'd1;
            end
        end
    end

    assign rx_ready_o  = (r_state != ST_WRITE);
    assign busy_o      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign done_o      = (r_state == ST_DONE);
    assign fetch_en_o  = done_o;
    assign err_o       = (r_state == ST_ERR);
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_req;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

endmodule

// File: tb/tb_boot_loader_wr.sv
// Directed bench for boot_loader_wr: frame table plus stall, junk/misalign and reset sequences.
module tb_boot_loader_wr;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b1;
    logic        busy_o, done_o, fetch_en_o, err_o;

    boot_loader_wr #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .busy_o(busy_o), .done_o(done_o), .fetch_en_o(fetch_en_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];
    int          nreq = 0;
    int          tie_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: samples just after the falling edge, after the bench drives.
    always begin
        @(negedge clk_i);
        #1;
        if (mem_req_o === 1'b1) nreq++;
        if (mem_req_o === 1'b1 && mem_gnt_i) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_wdata_o);
            wr_be.push_back(mem_be_o);
        end
        if (mem_we_o !== mem_req_o || fetch_en_o !== done_o || (done_o && err_o)) tie_bad++;
    end

    function automatic logic [7:0] calc_chk(input logic [31:0] a, input logic [15:0] c,
                                            input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0] x;
        x = c[7:0] ^ c[15:8];
        for (int i = 0; i < 4; i++) begin
            x = x ^ a[8*i +: 8];
            if (c >= 16'd1) x = x ^ w0[8*i +: 8];
            if (c >= 16'd2) x = x ^ w1[8*i +: 8];
        end
        return x;
    endfunction

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_be.delete();
        nreq = 0;
    endtask

    task automatic do_reset();
        rx_valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        clear_log();
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        n = 0;
        while (!rx_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("rx_ready_timeout", 64'd0, 64'd1);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [15:0] c);
        send_byte(8'hA5);
        send_word(a);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, rx_ready_o, 1'b1);
        chk({tag, "_req"}, mem_req_o, 1'b0);
        chk({tag, "_we"}, mem_we_o, 1'b0);
        chk({tag, "_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_be"}, mem_be_o, 4'h0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_fetch"}, fetch_en_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] cnt;
        logic [31:0] w0, w1;
        bit          bad_chk;
        bit          exp_done, exp_err;
        int          exp_nwr;
        logic [31:0] exp_a0, exp_a1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] a_hold, d_hold;
        int          n0;

        tbl[0] = '{32'h0000_1000, 16'd2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 2, 32'h0000_1000, 32'h0000_1004};
        tbl[1] = '{32'h0000_1000, 16'd2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 2, 32'h0000_1000, 32'h0000_1004};
        tbl[2] = '{32'h0000_0002, 16'd1, 32'h1111_2222, 32'h0,         1'b0, 1'b0, 1'b1, 0, 32'h0,         32'h0};
        tbl[3] = '{32'h0000_0040, 16'd0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 0, 32'h0,         32'h0};
        tbl[4] = '{32'hFFFF_FFFC, 16'd2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0, 1'b1, 1'b0, 2, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[5] = '{32'h0000_0100, 16'd1, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b1, 1'b0, 1, 32'h0000_0100, 32'h0};

        #1;
        check_reset_vals("reset");
        do_reset();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            mem_gnt_i = 1'b1;
            send_hdr(tbl[v].addr, tbl[v].cnt);
            if (tbl[v].cnt >= 16'd1) send_word(tbl[v].w0);
            if (tbl[v].cnt >= 16'd2) send_word(tbl[v].w1);
            chk($sformatf("v%0d_done_before_chk", v), done_o, 1'b0);
            send_byte(calc_chk(tbl[v].addr, tbl[v].cnt, tbl[v].w0, tbl[v].w1) ^ (tbl[v].bad_chk ? 8'hFF : 8'h00));
            chk($sformatf("v%0d_done", v), done_o, tbl[v].exp_done);
            chk($sformatf("v%0d_fetch", v), fetch_en_o, tbl[v].exp_done);
            chk($sformatf("v%0d_err", v), err_o, tbl[v].exp_err);
            chk($sformatf("v%0d_nwr", v), wr_addr.size(), tbl[v].exp_nwr);
            if (tbl[v].exp_nwr >= 1 && wr_addr.size() >= 1) begin
                chk($sformatf("v%0d_a0", v), wr_addr[0], tbl[v].exp_a0);
                chk($sformatf("v%0d_d0", v), wr_data[0], tbl[v].w0);
                chk($sformatf("v%0d_be0", v), wr_be[0], 4'hF);
            end
            if (tbl[v].exp_nwr >= 2 && wr_addr.size() >= 2) begin
                chk($sformatf("v%0d_a1", v), wr_addr[1], tbl[v].exp_a1);
                chk($sformatf("v%0d_d1", v), wr_data[1], tbl[v].w1);
            end
            // Terminal states ignore everything, including a fresh SYNC.
            n0 = nreq;
            send_hdr(32'h0000_2000, 16'd1);
            send_word(32'h0);
            chk($sformatf("v%0d_post_nreq", v), nreq, n0);
            chk($sformatf("v%0d_post_done", v), done_o, tbl[v].exp_done);
            chk($sformatf("v%0d_post_err", v), err_o, tbl[v].exp_err);
            chk($sformatf("v%0d_post_ready", v), rx_ready_o, 1'b1);
        end

        // Junk before SYNC, then a misaligned address.
        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        chk("junk_busy", busy_o, 1'b0);
        send_byte(8'hA5);
        chk("sync_busy", busy_o, 1'b1);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        chk("mis_err_early", err_o, 1'b0);
        send_byte(8'h00);
        chk("mis_err", err_o, 1'b1);
        chk("mis_busy", busy_o, 1'b0);
        chk("mis_nreq", nreq, 0);

        // Grant withheld for 7 cycles on the first write.
        do_reset();
        mem_gnt_i = 1'b0;
        send_hdr(32'h0000_1000, 16'd2);
        send_word(32'hDEAD_BEEF);
        chk("stall_req_latency", mem_req_o, 1'b1);
        chk("stall_ready0", rx_ready_o, 1'b0);
        a_hold = mem_addr_o;
        d_hold = mem_wdata_o;
        chk("stall_addr", a_hold, 32'h0000_1000);
        chk("stall_data", d_hold, 32'hDEAD_BEEF);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk_i);
            if (c == 8) mem_gnt_i = 1'b1;
            chk($sformatf("stall_c%0d_req", c), mem_req_o, 1'b1);
            chk($sformatf("stall_c%0d_ready", c), rx_ready_o, 1'b0);
            chk($sformatf("stall_c%0d_stable", c), {mem_addr_o, mem_wdata_o}, {a_hold, d_hold});
        end
        @(negedge clk_i);
        chk("stall_req_drop", mem_req_o, 1'b0);
        chk("stall_ready_back", rx_ready_o, 1'b1);
        send_word(32'h1234_5678);
        send_byte(calc_chk(32'h0000_1000, 16'd2, 32'hDEAD_BEEF, 32'h1234_5678));
        chk("stall_done", done_o, 1'b1);
        chk("stall_nwr", wr_addr.size(), 2);
        if (wr_data.size() == 2) chk("stall_d1", wr_data[1], 32'h1234_5678);
        chk("stall_nreq", nreq, 9);

        // Reset after the first grant, then a clean reload.
        do_reset();
        send_hdr(32'h0000_1000, 16'd2);
        send_word(32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("rst_pre_addr", mem_addr_o, 32'h0000_1004);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        clear_log();
        send_hdr(32'h0000_1000, 16'd2);
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        send_byte(calc_chk(32'h0000_1000, 16'd2, 32'hDEAD_BEEF, 32'h1234_5678));
        chk("rst_reload_done", done_o, 1'b1);
        chk("rst_reload_err", err_o, 1'b0);
        chk("rst_reload_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) chk("rst_reload_a1", wr_addr[1], 32'h0000_1004);

        @(negedge clk_i);
        chk("tie_violations", tie_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
